// File: rtl/led_share_pkg.sv
// Shared types and default sizing for the LED bank arbiter.
package led_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_LED_W      = 5;
    localparam int DEF_MIN_HOLD   = 4;
    localparam int DEF_MAX_CYCLES = 8;

    localparam int CNT_W = $clog2(DEF_MAX_CYCLES);
    localparam int IDX_W = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/led_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          found_o
);

    always_comb begin
        logic [IW-1:0] idx;
        idx      = '0;
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/led_share_arbiter.sv
// Time-shares one LED bank between several units with min-hold / max-tenure fairness.
module led_share_arbiter
    import led_share_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int LED_W      = DEF_LED_W,
    parameter int MIN_HOLD   = DEF_MIN_HOLD,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] led_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [LED_W-1:0]         led_out
);

    localparam int CW = $clog2(MAX_CYCLES);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      own_cnt_q, own_cnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic [IW-1:0]      winner;
    logic               found;
    logic [LED_W-1:0]   led_sel;
    logic               rel_hold, rel_max;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    always_comb begin
        led_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IW'(i)) led_sel = led_in[i*LED_W +: LED_W];
        end
    end

    assign rel_hold = (own_cnt_q >= CW'(MIN_HOLD - 1)) && !req[owner_q];
    assign rel_max  = (own_cnt_q == CW'(MAX_CYCLES - 1)) && ((req & ~grant_q) != '0);

    always_comb begin
        state_d   = state_q;
        own_cnt_d = own_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        grant_d   = '0;
        led_d     = '0;
        unique case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                if (found) begin
                    state_d   = OWN;
                    owner_d   = winner;
                    grant_d   = NUM_REQ'(1) << winner;
                    own_cnt_d = '0;
                    rr_ptr_d  = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            OWN: begin
                if (rel_hold || rel_max) begin
                    state_d   = GAP;
                    own_cnt_d = '0;
                end else begin
                    grant_d = grant_q;
                    led_d   = led_sel;
                    // Saturate so an uncontested owner can hold the bank forever.
                    if (own_cnt_q != CW'(MAX_CYCLES - 1)) own_cnt_d = own_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_cnt_q <= '0;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            own_cnt_q <= own_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            led_q     <= led_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == OWN);
    assign led_out = led_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter with hand-computed expectations.
module tb_led_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [14:0] led_in;
    logic [2:0]  grant;
    logic        busy;
    logic [4:0]  led_out;

    logic [4:0]  sl [3];
    int          checks;
    int          errors;

    led_share_arbiter #(
        .NUM_REQ(3), .LED_W(5), .MIN_HOLD(4), .MAX_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .led_in  (led_in),
        .grant   (grant),
        .busy    (busy),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_leds();
        led_in = {sl[2], sl[1], sl[0]};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic b, input logic [4:0] l);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".led"}, 32'(led_out), 32'(l));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sl[0] = 5'b00011;
        sl[1] = 5'b10101;
        sl[2] = 5'b11100;
        drive_leds();
        rst_n = 1'b0;
        req   = 3'b111;

        // Reset held with all requests up
        tick();
        chk_out("reset", 3'b000, 1'b0, 5'b00000);
        tick();
        chk_out("reset2", 3'b000, 1'b0, 5'b00000);
        rst_n = 1'b1;

        // Round-robin with continuous requests: 0,1,2,0; 8-cycle tenures, 1-cycle gaps
        tick();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("rr%0d.c%0d.grant", r, c), 32'(grant), 32'(3'b001 << (r % 3)));
                chk($sformatf("rr%0d.c%0d.busy", r, c), 32'(busy), 32'd1);
                if (c == 0) chk($sformatf("rr%0d.c0.led", r), 32'(led_out), 32'd0);
                else        chk($sformatf("rr%0d.c%0d.led", r, c), 32'(led_out), 32'(sl[r % 3]));
                tick();
            end
            chk_out($sformatf("rr%0d.gap", r), 3'b000, 1'b0, 5'b00000);
            if (r == 3) req = 3'b000;
            if (r < 3) tick();
        end
        tick();
        chk_out("idle_after_rr", 3'b000, 1'b0, 5'b00000);

        // Single requester dropping early: hold enforced for 4 cycles, led tracks input
        req = 3'b010;
        tick();
        chk_out("single.c0", 3'b010, 1'b1, 5'b00000);
        req = 3'b000;
        tick();
        chk_out("single.c1", 3'b010, 1'b1, 5'b10101);
        sl[1] = 5'b01010;
        drive_leds();
        tick();
        chk_out("single.c2", 3'b010, 1'b1, 5'b01010);
        tick();
        chk_out("single.c3", 3'b010, 1'b1, 5'b01010);
        tick();
        chk_out("single.gap", 3'b000, 1'b0, 5'b00000);
        tick();
        chk_out("single.idle", 3'b000, 1'b0, 5'b00000);

        // Handoff: owner 0 drops at own_cnt=5 while unit 2 waits
        req = 3'b001;
        tick();
        chk_out("hand.c0", 3'b001, 1'b1, 5'b00000);
        tick();
        tick();
        req = 3'b101;
        tick();
        tick();
        tick();
        chk_out("hand.c5", 3'b001, 1'b1, 5'b00011);
        req = 3'b100;
        tick();
        chk_out("hand.gap", 3'b000, 1'b0, 5'b00000);
        tick();
        chk_out("hand.own2", 3'b100, 1'b1, 5'b00000);
        tick();
        chk_out("hand.led2", 3'b100, 1'b1, 5'b11100);

        // Async reset between edges clears outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 3'b000, 1'b0, 5'b00000);
        #3;
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 3'b100, 1'b1, 5'b00000);

        // No contention: owner 0 alone for 20 cycles, then forced out by unit 1
        req = 3'b001;
        tick();
        tick();
        tick();
        chk_out("post_rst.c3", 3'b100, 1'b1, 5'b11100);
        tick();
        chk_out("nc.gap", 3'b000, 1'b0, 5'b00000);
        tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("nc.c%0d.grant", c), 32'(grant), 32'(3'b001));
            tick();
        end
        chk_out("nc.sat", 3'b001, 1'b1, 5'b00011);
        req = 3'b011;
        tick();
        chk_out("force.gap", 3'b000, 1'b0, 5'b00000);
        tick();
        chk_out("force.own1", 3'b010, 1'b1, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
